// File: rtl/prog_load_ctrl.sv
// Streams a program image (header, imem lines, dmem words, optional checksum trailer) into imem/dmem.
// Optional PLOAD_CHECKSUM_EN adds a CHK state that compares a trailer beat against the running beat sum.
module prog_load_ctrl #(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
  parameter int          IMEM_LINES = 512
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  output logic         prog_loading,
  output logic         imem_we,
  output logic [8:0]   imem_addr,
  output logic [127:0] imem_wdata,
  output logic         dmem_we,
  output logic [31:0]  dmem_addr,
  output logic [31:0]  dmem_wdata,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    IMEM = 3'd2,
    DMEM = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [9:0] MAX_LINES = 10'(IMEM_LINES);

`ifdef PLOAD_CHECKSUM_EN
  localparam state_t POST_DATA = CHK;
`else
  localparam state_t POST_DATA = DONE;
`endif

  state_t         state_q, state_d;
  logic [9:0]     imem_cnt_q, imem_cnt_d;
  logic [15:0]    dmem_cnt_q, dmem_cnt_d;
  logic [9:0]     line_idx_q, line_idx_d;
  logic [1:0]     beat_k_q, beat_k_d;
  logic [95:0]    pack_q, pack_d;
  logic [15:0]    dmem_idx_q, dmem_idx_d;
  logic           imem_we_q, imem_we_d;
  logic [8:0]     imem_addr_q, imem_addr_d;
  logic [127:0]   imem_wdata_q, imem_wdata_d;
  logic           dmem_we_q, dmem_we_d;
  logic [31:0]    dmem_addr_q, dmem_addr_d;
  logic [31:0]    dmem_wdata_q, dmem_wdata_d;
  logic           prog_loading_q, prog_loading_d;
  logic           done_q, done_d;
`ifdef PLOAD_CHECKSUM_EN
  logic [31:0]    sum_q, sum_d;
  logic           err_q, err_d;
`endif

  logic           accept;
  logic [9:0]     hdr_imem;
  logic [9:0]     line_nxt;
  logic [15:0]    dmem_nxt;

  assign in_ready = (state_q == HDR) || (state_q == IMEM) ||
                    (state_q == DMEM) || (state_q == CHK);
  assign accept   = in_valid && in_ready;
  assign hdr_imem = (in_data[9:0] > MAX_LINES) ? MAX_LINES : in_data[9:0];
  assign line_nxt = line_idx_q + 10'd1;
  assign dmem_nxt = dmem_idx_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    imem_cnt_d     = imem_cnt_q;
    dmem_cnt_d     = dmem_cnt_q;
    line_idx_d     = line_idx_q;
    beat_k_d       = beat_k_q;
    pack_d         = pack_q;
    dmem_idx_d     = dmem_idx_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    dmem_we_d      = 1'b0;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    prog_loading_d = prog_loading_q;
    done_d         = done_q;
`ifdef PLOAD_CHECKSUM_EN
    sum_d          = sum_q;
    err_d          = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = HDR;
          done_d         = 1'b0;
          prog_loading_d = 1'b1;
`ifdef PLOAD_CHECKSUM_EN
          err_d          = 1'b0;
`endif
        end
      end

      HDR: begin
        if (accept) begin
          imem_cnt_d = hdr_imem;
          dmem_cnt_d = in_data[31:16];
          line_idx_d = 10'd0;
          beat_k_d   = 2'd0;
          dmem_idx_d = 16'd0;
`ifdef PLOAD_CHECKSUM_EN
          sum_d      = 32'd0;
`endif
          if (hdr_imem != 10'd0) begin
            state_d = IMEM;
          end else if (in_data[31:16] != 16'd0) begin
            state_d = DMEM;
          end else begin
            state_d = POST_DATA;
          end
        end
      end

      IMEM: begin
        if (accept) begin
`ifdef PLOAD_CHECKSUM_EN
          sum_d    = sum_q + in_data;
`endif
          beat_k_d = beat_k_q + 2'd1;
          case (beat_k_q)
            2'd0: pack_d[31:0]  = in_data;
            2'd1: pack_d[63:32] = in_data;
            2'd2: pack_d[95:64] = in_data;
            default: begin
              // Fourth beat completes the line straight from the bus; the buffer holds beats 0..2.
              imem_we_d    = 1'b1;
              imem_addr_d  = line_idx_q[8:0];
              imem_wdata_d = {in_data, pack_q};
              line_idx_d   = line_nxt;
              if (line_nxt == imem_cnt_q) begin
                state_d = (dmem_cnt_q != 16'd0) ? DMEM : POST_DATA;
              end
            end
          endcase
        end
      end

      DMEM: begin
        if (accept) begin
`ifdef PLOAD_CHECKSUM_EN
          sum_d        = sum_q + in_data;
`endif
          dmem_we_d    = 1'b1;
          dmem_addr_d  = DMEM_BASE + {14'd0, dmem_idx_q, 2'b00};
          dmem_wdata_d = in_data;
          dmem_idx_d   = dmem_nxt;
          if (dmem_nxt == dmem_cnt_q) begin
            state_d = POST_DATA;
          end
        end
      end

`ifdef PLOAD_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          err_d   = (in_data != sum_q);
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        // First DONE cycle coincides with the last write strobe; release the core one cycle later.
        if (start) begin
          state_d        = HDR;
          done_d         = 1'b0;
          prog_loading_d = 1'b1;
`ifdef PLOAD_CHECKSUM_EN
          err_d          = 1'b0;
`endif
        end else begin
          done_d         = 1'b1;
          prog_loading_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      imem_cnt_q     <= 10'd0;
      dmem_cnt_q     <= 16'd0;
      line_idx_q     <= 10'd0;
      beat_k_q       <= 2'd0;
      pack_q         <= 96'd0;
      dmem_idx_q     <= 16'd0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= 9'd0;
      imem_wdata_q   <= 128'd0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= 32'd0;
      dmem_wdata_q   <= 32'd0;
      prog_loading_q <= 1'b1;
      done_q         <= 1'b0;
`ifdef PLOAD_CHECKSUM_EN
      sum_q          <= 32'd0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      imem_cnt_q     <= imem_cnt_d;
      dmem_cnt_q     <= dmem_cnt_d;
      line_idx_q     <= line_idx_d;
      beat_k_q       <= beat_k_d;
      pack_q         <= pack_d;
      dmem_idx_q     <= dmem_idx_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      dmem_we_q      <= dmem_we_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
      prog_loading_q <= prog_loading_d;
      done_q         <= done_d;
`ifdef PLOAD_CHECKSUM_EN
      sum_q          <= sum_d;
      err_q          <= err_d;
`endif
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign prog_loading = prog_loading_q;
  assign done         = done_q;
`ifdef PLOAD_CHECKSUM_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: write strobes are logged on the falling edge and compared to hand-computed values.
module tb_prog_load_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, in_valid;
  logic [31:0]  in_data;
  logic         in_ready, prog_loading, imem_we, dmem_we, done, err;
  logic [8:0]   imem_addr;
  logic [127:0] imem_wdata;
  logic [31:0]  dmem_addr, dmem_wdata;

  prog_load_ctrl #(.DMEM_BASE(32'h0000_0000), .IMEM_LINES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .prog_loading(prog_loading),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

`ifdef PLOAD_CHECKSUM_EN
  localparam int POST_GAP = 2;
`else
  localparam int POST_GAP = 1;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_strobe = 0;
  int fall_cyc = 0;
  int both_cnt = 0;
  int stalls = 0;
  logic pl_prev = 1'b1;

  logic [8:0]   ia_q[$];
  logic [127:0] id_q[$];
  logic [31:0]  da_q[$];
  logic [31:0]  dd_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we) begin
      ia_q.push_back(imem_addr);
      id_q.push_back(imem_wdata);
      last_strobe = cyc;
    end
    if (dmem_we) begin
      da_q.push_back(dmem_addr);
      dd_q.push_back(dmem_wdata);
      last_strobe = cyc;
    end
    if (imem_we && dmem_we) both_cnt = both_cnt + 1;
    if (pl_prev && !prog_loading) fall_cyc = cyc;
    pl_prev = prog_loading;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ia_q.delete(); id_q.delete(); da_q.delete(); dd_q.delete();
  endtask

  // Called on a falling edge; returns on the falling edge after the beat was taken.
  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    stalls += n;
    if (!in_ready) check("send_timeout", 128'd0, 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic trailer(input logic [31:0] s);
`ifdef PLOAD_CHECKSUM_EN
    send(s);
`else
    if (s == 32'hFFFF_FFFF) $display("unused trailer");
`endif
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, {127'd0, done}, 128'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] sum;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_prog_loading", {127'd0, prog_loading}, 128'd1);
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_err", {127'd0, err}, 128'd0);
    check("rst_we", {126'd0, imem_we, dmem_we}, 128'd0);
    check("rst_imem_wdata", imem_wdata, 128'd0);
    check("rst_dmem_addr", {96'd0, dmem_addr}, 128'd0);
    reset = 1'b0;
    @(negedge clk);
    clear_logs();

    // 1 imem line + 1 dmem word, streamed back-to-back
    do_start();
    stalls = 0;
    send(32'h0001_0001);
    for (int i = 1; i <= 5; i++) send(32'(i));
    trailer(32'd15);
    wait_done("t1_done");
    check("t1_no_stall", 128'(stalls), 128'd0);
    check("t1_imem_n", 128'(ia_q.size()), 128'd1);
    check("t1_imem_addr", 128'(ia_q[0]), 128'd0);
    check("t1_imem_data", id_q[0], {32'd4, 32'd3, 32'd2, 32'd1});
    check("t1_dmem_n", 128'(da_q.size()), 128'd1);
    check("t1_dmem_addr", 128'(da_q[0]), 128'd0);
    check("t1_dmem_data", 128'(dd_q[0]), 128'd5);
    check("t1_pl_gap", 128'(fall_cyc - last_strobe), 128'(POST_GAP));
    check("t1_prog_loading", {127'd0, prog_loading}, 128'd0);
    check("t1_err", {127'd0, err}, 128'd0);
    clear_logs();

    // empty image
    do_start();
    #1;
    check("t2_done_cleared", {127'd0, done}, 128'd0);
    check("t2_prog_loading_set", {127'd0, prog_loading}, 128'd1);
    send(32'h0000_0000);
    trailer(32'd0);
    wait_done("t2_done");
    check("t2_no_writes", 128'(ia_q.size() + da_q.size()), 128'd0);
    check("t2_err", {127'd0, err}, 128'd0);
    check("t2_prog_loading", {127'd0, prog_loading}, 128'd0);
    clear_logs();

    // 3 lines with in_valid toggling
    do_start();
    send(32'h0000_0003);
    sum = 32'd0;
    for (int i = 0; i < 12; i++) begin
      send(32'h100 + 32'(i));
      sum += 32'h100 + 32'(i);
      @(negedge clk);
    end
    trailer(sum);
    wait_done("t3_done");
    check("t3_imem_n", 128'(ia_q.size()), 128'd3);
    for (int l = 0; l < 3; l++) begin
      check("t3_addr", 128'(ia_q[l]), 128'(l));
      check("t3_data", id_q[l], {32'h103 + 32'(4*l), 32'h102 + 32'(4*l), 32'h101 + 32'(4*l), 32'h100 + 32'(4*l)});
    end
    check("t3_err", {127'd0, err}, 128'd0);
    clear_logs();

    // reset mid-line discards the partial line
    do_start();
    send(32'h0000_0001);
    send(32'h0000_00AA);
    send(32'h0000_00BB);
    do_reset();
    repeat (3) @(negedge clk);
    check("t4_no_imem_we", 128'(ia_q.size()), 128'd0);
    check("t4_prog_loading", {127'd0, prog_loading}, 128'd1);
    check("t4_imem_wdata_rst", imem_wdata, 128'd0);
    do_start();
    send(32'h0000_0001);
    send(32'h11); send(32'h22); send(32'h33); send(32'h44);
    trailer(32'hAA);
    wait_done("t4_done");
    check("t4_imem_n", 128'(ia_q.size()), 128'd1);
    check("t4_addr", 128'(ia_q[0]), 128'd0);
    check("t4_data", id_q[0], {32'h44, 32'h33, 32'h22, 32'h11});
    clear_logs();

    // two dmem words, good checksum, then bad checksum
    do_start();
    send(32'h0002_0000);
    send(32'd7); send(32'd9);
    trailer(32'd16);
    wait_done("t5_done");
    check("t5_dmem_n", 128'(da_q.size()), 128'd2);
    check("t5_addr1", 128'(da_q[1]), 128'd4);
    check("t5_data1", 128'(dd_q[1]), 128'd9);
    check("t5_err", {127'd0, err}, 128'd0);
    clear_logs();
`ifdef PLOAD_CHECKSUM_EN
    do_start();
    send(32'h0002_0000);
    send(32'd7); send(32'd9);
    send(32'd17);
    wait_done("t5b_done");
    check("t5b_err", {127'd0, err}, 128'd1);
    clear_logs();
`endif

    // start while in DMEM is ignored
    do_start();
    send(32'h0003_0000);
    send(32'd10);
    start = 1'b1;
    send(32'd20);
    start = 1'b0;
    send(32'd30);
    trailer(32'd60);
    wait_done("t6_done");
    check("t6_dmem_n", 128'(da_q.size()), 128'd3);
    check("t6_addr2", 128'(da_q[2]), 128'd8);
    check("t6_data2", 128'(dd_q[2]), 128'd30);
    check("t6_err", {127'd0, err}, 128'd0);
    clear_logs();

    // header imem count 6 clamps to 4 lines; the next beat is dmem, across the boundary without stall
    do_start();
    send(32'h0001_0006);
    sum = 32'd0;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      send(32'h200 + 32'(i));
      sum += 32'h200 + 32'(i);
    end
    send(32'hCAFE);
    sum += 32'hCAFE;
    trailer(sum);
    wait_done("t7_done");
    check("t7_no_stall", 128'(stalls), 128'd0);
    check("t7_imem_n", 128'(ia_q.size()), 128'd4);
    check("t7_last_addr", 128'(ia_q[3]), 128'd3);
    check("t7_dmem_data", 128'(dd_q[0]), 128'hCAFE);
    check("t7_err", {127'd0, err}, 128'd0);
    check("never_both_we", 128'(both_cnt), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
